data_memory_responder: RTL and testbench

- Memory-side responder for the load/store requests the execute stage issues: MEM_READ, MEM_WRITE, FUNC3, ALU address and forwarded store data.
- Sits in the MEM stage and owns a word-organised data RAM with a configurable access latency.
- Performs RV32I byte/half/word stores and sign- or zero-extended loads.
- Drives BUSY to stall the pipeline during an access and returns the formatted load value on READ_DATA, which feeds MEM_RD_DATA forwarding and writeback.

---
 rtl/data_memory_responder.sv | 189 ++++++++++++++++++
 tb/tb_data_memory_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Brief    : MEM-stage load/store responder. Owns a word-organised data RAM
//            with a fixed multi-cycle access latency, performs RV32I byte/
//            half/word stores and sign/zero-extended loads, stalls the
//            pipeline through BUSY and flags illegal requests.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY,
  output logic        ACCESS_ERROR
);

  localparam int c_AW = $clog2(DEPTH_WORDS);
  localparam int c_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(LATENCY - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic            w_complete;
  logic            w_illegal;

  logic [31:0]     r_mem [0:DEPTH_WORDS-1];

  logic            w_req;
  logic            w_load_ok;
  logic            w_store_ok;
  logic            w_align_ok;
  logic            w_legal;
  logic [c_AW-1:0] w_idx;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load_val;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;

  // Address bits above the RAM index are intentionally ignored (wrap-around).
  wire w_unused = &{1'b0, ADDRESS[31:c_AW+2]};

  assign w_req = MEM_READ | MEM_WRITE;
  assign w_idx = ADDRESS[c_AW+1:2];

  // Request legality: supported FUNC3 codes, natural alignment, single direction.
  always_comb begin
    w_load_ok  = 1'b0;
    w_store_ok = 1'b0;
    w_align_ok = 1'b1;
    case (FUNC3)
      3'b000, 3'b001, 3'b010: begin
        w_load_ok  = 1'b1;
        w_store_ok = 1'b1;
      end
      3'b100, 3'b101: w_load_ok = 1'b1;
      default: ;
    endcase
    case (FUNC3[1:0])
      2'b01:   w_align_ok = ~ADDRESS[0];
      2'b10:   w_align_ok = (ADDRESS[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
    w_legal = (MEM_READ ^ MEM_WRITE) && w_align_ok &&
              (MEM_READ ? w_load_ok : w_store_ok);
  end

  // Next-state, counter and BUSY: BUSY covers the request cycle plus every
  // ACCESS cycle except the one where the counter has run down to zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    BUSY        = 1'b0;
    w_complete  = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_legal) begin
            BUSY        = 1'b1;
            w_state_nxt = S_ACCESS;
            w_cnt_nxt   = c_CNT_INIT;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          BUSY      = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Load formatting: pick the addressed byte/half and extend per FUNC3.
  always_comb begin
    w_word     = r_mem[w_idx];
    w_byte     = w_word[{ADDRESS[1:0], 3'b000} +: 8];
    w_half     = w_word[{ADDRESS[1], 4'b0000} +: 16];
    w_load_val = w_word;
    case (FUNC3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'h0, w_byte};
      3'b101:  w_load_val = {16'h0, w_half};
      default: w_load_val = w_word;
    endcase
  end

  // Store lane replication and byte enables.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WRITE_DATA;
    case (FUNC3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ADDRESS[1:0];
        w_wdata = {4{WRITE_DATA[7:0]}};
      end
      2'b01: begin
        w_be    = ADDRESS[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WRITE_DATA[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WRITE_DATA;
      end
    endcase
  end

  // Registered outputs: load result at completion, one-cycle error pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      READ_DATA    <= '0;
      ACCESS_ERROR <= 1'b0;
    end else begin
      ACCESS_ERROR <= w_illegal;
      if (w_complete && MEM_READ) begin
        READ_DATA <= w_load_val;
      end
    end
  end

  // RAM write only at a completion edge; reset abandons the pending store.
  always_ff @(posedge CLK) begin
    if (w_complete && MEM_WRITE && !RST) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_responder
// Brief    : Directed self-checking bench for data_memory_responder
//            (DEPTH_WORDS=256, LATENCY=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

  logic        CLK;
  logic        RST;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY;
  logic        ACCESS_ERROR;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
    .CLK(CLK), .RST(RST), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .FUNC3(FUNC3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
    .READ_DATA(READ_DATA), .BUSY(BUSY), .ACCESS_ERROR(ACCESS_ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Starts and ends 1 time unit after a rising edge. Holds the request until
  // the completion edge has passed; returns number of BUSY-high cycles.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int nbusy);
    MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; ADDRESS = a; WRITE_DATA = wd;
    nbusy = 0;
    #1;
    while (BUSY && nbusy < 20) begin
      nbusy++;
      @(posedge CLK); #2;
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    FUNC3 = 3'b000; ADDRESS = '0; WRITE_DATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({BUSY, ACCESS_ERROR, READ_DATA} !== 34'h0) begin
      errors++;
      $display("FAIL reset: busy=%0b err=%0b rd=0x%08h expected 0/0/0", BUSY, ACCESS_ERROR, READ_DATA);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_word_and_latency();
    int nb;
    access(1'b0, 1'b1, F_W, 32'h10, 32'hDEADBEEF, nb);
    idle();
    checks++;
    if (nb !== 3) begin errors++; $display("FAIL sw_busy_cycles: got %0d expected 3", nb); end
    access(1'b1, 1'b0, F_W, 32'h10, 32'h0, nb);
    checks++;
    if (nb !== 3) begin errors++; $display("FAIL lw_busy_cycles: got %0d expected 3", nb); end
    chk32("lw_0x10", READ_DATA, 32'hDEADBEEF);
    idle();
    checks++;
    if (ACCESS_ERROR !== 1'b0) begin errors++; $display("FAIL legal_no_error: got %0b expected 0", ACCESS_ERROR); end
  endtask

  task automatic test_byte_half();
    int nb;
    access(1'b0, 1'b1, F_B, 32'h11, 32'h000000AA, nb); idle();
    access(1'b1, 1'b0, F_W,  32'h10, 32'h0, nb); chk32("lw_after_sb", READ_DATA, 32'hDEADAAEF); idle();
    access(1'b1, 1'b0, F_B,  32'h11, 32'h0, nb); chk32("lb_0x11",  READ_DATA, 32'hFFFFFFAA); idle();
    access(1'b1, 1'b0, F_BU, 32'h11, 32'h0, nb); chk32("lbu_0x11", READ_DATA, 32'h000000AA); idle();
    access(1'b1, 1'b0, F_H,  32'h12, 32'h0, nb); chk32("lh_0x12",  READ_DATA, 32'hFFFFDEAD); idle();
    access(1'b1, 1'b0, F_HU, 32'h12, 32'h0, nb); chk32("lhu_0x12", READ_DATA, 32'h0000DEAD); idle();
    // SH to the low half of the same word, upper half must survive.
    access(1'b0, 1'b1, F_H,  32'h10, 32'h00001234, nb); idle();
    access(1'b1, 1'b0, F_W,  32'h10, 32'h0, nb); chk32("lw_after_sh", READ_DATA, 32'hDEAD1234); idle();
    // Restore the word expected by the following tests.
    access(1'b0, 1'b1, F_W,  32'h10, 32'hDEADAAEF, nb); idle();
  endtask

  task automatic test_illegal();
    int nb;
    logic [31:0] prev;
    logic       rd_v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       wr_v [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] f3_v [4] = '{F_W, F_H, 3'b011, F_W};
    logic [31:0] a_v [4] = '{32'h13, 32'h01, 32'h10, 32'h10};
    prev = READ_DATA;
    for (int i = 0; i < 4; i++) begin
      access(rd_v[i], wr_v[i], f3_v[i], a_v[i], 32'h55555555, nb);
      checks++;
      if (nb !== 0) begin errors++; $display("FAIL illegal%0d_busy: got %0d busy cycles expected 0", i, nb); end
      checks++;
      if (ACCESS_ERROR !== 1'b1) begin errors++; $display("FAIL illegal%0d_err_pulse: got %0b expected 1", i, ACCESS_ERROR); end
      idle();
      checks++;
      if (ACCESS_ERROR !== 1'b0) begin errors++; $display("FAIL illegal%0d_err_one_cycle: got %0b expected 0", i, ACCESS_ERROR); end
      chk32("illegal_rd_unchanged", READ_DATA, prev);
    end
    access(1'b1, 1'b0, F_W, 32'h10, 32'h0, nb);
    chk32("ram_after_illegal", READ_DATA, 32'hDEADAAEF);
    idle();
  endtask

  task automatic test_wrap();
    int nb;
    access(1'b0, 1'b1, F_W, 32'h400, 32'h12345678, nb); idle();
    access(1'b1, 1'b0, F_W, 32'h0, 32'h0, nb);
    chk32("wrap_lw_0x0", READ_DATA, 32'h12345678);
    idle();
  endtask

  task automatic test_reset_in_access();
    int nb;
    access(1'b0, 1'b1, F_W, 32'h20, 32'h0, nb); idle();
    MEM_READ = 1'b0; MEM_WRITE = 1'b1; FUNC3 = F_W; ADDRESS = 32'h20; WRITE_DATA = 32'h1;
    @(posedge CLK);          // enters first ACCESS cycle
    @(posedge CLK); #1;      // second ACCESS cycle
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; MEM_WRITE = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_in_access_busy: got %0b expected 0", BUSY); end
    chk32("rst_in_access_rd", READ_DATA, 32'h0);
    @(posedge CLK); #1;
    access(1'b1, 1'b0, F_W, 32'h20, 32'h0, nb);
    chk32("rst_store_dropped", READ_DATA, 32'h0);
    idle();
  endtask

  task automatic test_back_to_back();
    int nb1, nb2;
    access(1'b1, 1'b0, F_W, 32'h10, 32'h0, nb1);
    chk32("b2b_first", READ_DATA, 32'hDEADAAEF);
    access(1'b1, 1'b0, F_W, 32'h14, 32'h0, nb2);
    chk32("b2b_second", READ_DATA, 32'h00000000);
    checks++;
    if (nb1 !== 3 || nb2 !== 3) begin
      errors++;
      $display("FAIL b2b_busy: got %0d/%0d busy cycles expected 3/3", nb1, nb2);
    end
    idle();
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_no_duplicate: busy=%0b expected 0", BUSY); end
  endtask

  initial begin
    test_reset();
    test_word_and_latency();
    test_byte_half();
    test_illegal();
    test_wrap();
    // Give word 0x14 a known value for the back-to-back pair.
    begin
      int nb;
      access(1'b0, 1'b1, F_W, 32'h14, 32'h0, nb); idle();
    end
    test_reset_in_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
